cmp_streak_monitor: RTL and testbench

Downstream consumer of the 4-bit magnitude comparator's equal/less/greater flags. On every valid sample it counts outcomes, tracks consecutive greater-than results, and raises a debounced alarm with separate assert and release thresholds. It also flags malformed (non-one-hot) comparator results. It is used for over-threshold detection where the comparator checks a live value against a limit.

---
 rtl/cmp_streak_monitor.sv | 149 ++++++++++++++
 tb/tb_cmp_streak_monitor.sv | 132 +++++++++++++
 2 files changed

// File: rtl/cmp_streak_monitor.sv
// rtl/cmp_streak_monitor.sv - debounced gt-streak alarm and outcome counters for a magnitude comparator
// Counts one-hot comparator outcomes, flags malformed ones and runs the alarm FSM.
module cmp_streak_monitor #(
  parameter int THRESH  = 3,
  parameter int RELEASE = 2,
  parameter int CNT_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             eq,
  input  logic             lt,
  input  logic             gt,
  input  logic             clr,
  output logic             alarm,
  output logic             alarm_rise,
  output logic [3:0]       run,
  output logic [CNT_W-1:0] eq_cnt,
  output logic [CNT_W-1:0] lt_cnt,
  output logic [CNT_W-1:0] gt_cnt,
  output logic             err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMING,
    S_ALARM,
    S_RELEASING
  } state_t;

  localparam logic [4:0]       THRESH_V  = 5'(THRESH);
  localparam logic [4:0]       RELEASE_V = 5'(RELEASE);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           r_state;
  logic             r_alarm;
  logic             r_alarm_rise;
  logic [3:0]       r_run;
  logic [CNT_W-1:0] r_eq_cnt;
  logic [CNT_W-1:0] r_lt_cnt;
  logic [CNT_W-1:0] r_gt_cnt;
  logic             r_err;

  logic       w_onehot;
  logic       w_accept;
  logic       w_malformed;
  logic [4:0] w_run_inc;

  assign w_onehot    = ({eq, lt, gt} == 3'b100) || ({eq, lt, gt} == 3'b010) ||
                       ({eq, lt, gt} == 3'b001);
  assign w_accept    = in_valid & w_onehot;
  assign w_malformed = in_valid & ~w_onehot;
  // Widened so run+1 can be compared against thresholds up to 15 without wrap.
  assign w_run_inc   = {1'b0, r_run} + 5'd1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_alarm      <= 1'b0;
      r_alarm_rise <= 1'b0;
      r_run        <= '0;
      r_eq_cnt     <= '0;
      r_lt_cnt     <= '0;
      r_gt_cnt     <= '0;
      r_err        <= 1'b0;
    end else begin
      r_alarm_rise <= 1'b0;

      // clr wins over any increment or error set in the same cycle.
      if (clr) begin
        r_eq_cnt <= '0;
        r_lt_cnt <= '0;
        r_gt_cnt <= '0;
        r_err    <= 1'b0;
      end else begin
        if (w_malformed) r_err <= 1'b1;
        if (w_accept && eq && r_eq_cnt != CNT_MAX) r_eq_cnt <= r_eq_cnt + 1'b1;
        if (w_accept && lt && r_lt_cnt != CNT_MAX) r_lt_cnt <= r_lt_cnt + 1'b1;
        if (w_accept && gt && r_gt_cnt != CNT_MAX) r_gt_cnt <= r_gt_cnt + 1'b1;
      end

      if (w_accept) begin
        case (r_state)
          S_IDLE: begin
            if (gt) begin
              r_state <= S_ARMING;
              r_run   <= 4'd1;
            end else begin
              r_run   <= '0;
            end
          end
          S_ARMING: begin
            if (gt) begin
              if (w_run_inc == THRESH_V) begin
                r_state      <= S_ALARM;
                r_alarm      <= 1'b1;
                r_alarm_rise <= 1'b1;
                r_run        <= '0;
              end else begin
                r_run <= w_run_inc[3:0];
              end
            end else begin
              r_state <= S_IDLE;
              r_run   <= '0;
            end
          end
          S_ALARM: begin
            if (gt) begin
              r_run <= '0;
            end else if (RELEASE_V == 5'd1) begin
              r_state <= S_IDLE;
              r_alarm <= 1'b0;
              r_run   <= '0;
            end else begin
              r_state <= S_RELEASING;
              r_run   <= 4'd1;
            end
          end
          S_RELEASING: begin
            if (gt) begin
              r_state <= S_ALARM;
              r_run   <= '0;
            end else if (w_run_inc == RELEASE_V) begin
              r_state <= S_IDLE;
              r_alarm <= 1'b0;
              r_run   <= '0;
            end else begin
              r_run <= w_run_inc[3:0];
            end
          end
          default: begin
            r_state <= S_IDLE;
            r_alarm <= 1'b0;
            r_run   <= '0;
          end
        endcase
      end
    end
  end

  assign alarm      = r_alarm;
  assign alarm_rise = r_alarm_rise;
  assign run        = r_run;
  assign eq_cnt     = r_eq_cnt;
  assign lt_cnt     = r_lt_cnt;
  assign gt_cnt     = r_gt_cnt;
  assign err        = r_err;

endmodule

// File: tb/tb_cmp_streak_monitor.sv
// tb/tb_cmp_streak_monitor.sv - directed-vector bench for cmp_streak_monitor
// Table of {inputs, expected outputs} plus hand sequences for gaps, saturation and reset.
module tb_cmp_streak_monitor;

  logic       clk = 1'b0;
  logic       rst_n, in_valid, eq, lt, gt, clr;
  logic       alarm, alarm_rise, err;
  logic [3:0] run;
  logic [7:0] eq_cnt, lt_cnt, gt_cnt;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic       rst_n, in_valid, eq, lt, gt, clr;
    logic       alarm, alarm_rise;
    logic [3:0] run;
    logic [7:0] eq_cnt, lt_cnt, gt_cnt;
    logic       err;
  } vec_t;

  vec_t vecs[$];

  cmp_streak_monitor #(.THRESH(3), .RELEASE(2), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .eq(eq), .lt(lt), .gt(gt), .clr(clr),
    .alarm(alarm), .alarm_rise(alarm_rise), .run(run),
    .eq_cnt(eq_cnt), .lt_cnt(lt_cnt), .gt_cnt(gt_cnt), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic r, v, e, l, g, c, ea, er, input logic [3:0] erun,
                     input logic [7:0] eeq, elt, egt, input logic eerr);
    vec_t t;
    t.rst_n = r; t.in_valid = v; t.eq = e; t.lt = l; t.gt = g; t.clr = c;
    t.alarm = ea; t.alarm_rise = er; t.run = erun;
    t.eq_cnt = eeq; t.lt_cnt = elt; t.gt_cnt = egt; t.err = eerr;
    vecs.push_back(t);
  endtask

  task automatic step(input logic r, v, e, l, g, c);
    @(negedge clk);
    rst_n = r; in_valid = v; eq = e; lt = l; gt = g; clr = c;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; eq = 1'b0; lt = 1'b0; gt = 1'b0; clr = 1'b0;

    //   rst v  eq lt gt clr | alarm rise run eq lt gt err
    add(0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0,   0, 0, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0,   0, 0, 2, 0, 0, 2, 0);
    add(1, 1, 0, 0, 1, 0,   1, 1, 0, 0, 0, 3, 0);
    add(1, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 0);
    add(1, 1, 0, 1, 0, 0,   1, 0, 1, 0, 1, 3, 0);
    add(1, 1, 0, 0, 1, 0,   1, 0, 0, 0, 1, 4, 0);
    add(1, 1, 1, 0, 0, 0,   1, 0, 1, 1, 1, 4, 0);
    add(1, 1, 1, 0, 0, 0,   0, 0, 0, 2, 1, 4, 0);
    add(0, 1, 0, 0, 1, 0,   0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0,   0, 0, 1, 0, 0, 1, 0);
    add(1, 1, 0, 0, 1, 0,   0, 0, 2, 0, 0, 2, 0);
    add(1, 1, 0, 1, 0, 0,   0, 0, 0, 0, 1, 2, 0);
    add(1, 1, 0, 0, 1, 0,   0, 0, 1, 0, 1, 3, 0);
    add(1, 1, 0, 0, 1, 0,   0, 0, 2, 0, 1, 4, 0);
    add(1, 1, 1, 0, 1, 0,   0, 0, 2, 0, 1, 4, 1);
    add(1, 1, 0, 0, 0, 0,   0, 0, 2, 0, 1, 4, 1);
    add(1, 0, 1, 1, 1, 0,   0, 0, 2, 0, 1, 4, 1);
    add(1, 1, 0, 0, 1, 1,   1, 1, 0, 0, 0, 0, 0);
    add(1, 1, 0, 1, 1, 1,   1, 0, 0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 1, 0,   1, 0, 0, 0, 0, 1, 0);
    add(0, 1, 0, 0, 1, 1,   0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst_n, vecs[i].in_valid, vecs[i].eq, vecs[i].lt, vecs[i].gt, vecs[i].clr);
      chk("alarm", i, 32'(alarm), 32'(vecs[i].alarm));
      chk("alarm_rise", i, 32'(alarm_rise), 32'(vecs[i].alarm_rise));
      chk("run", i, 32'(run), 32'(vecs[i].run));
      chk("eq_cnt", i, 32'(eq_cnt), 32'(vecs[i].eq_cnt));
      chk("lt_cnt", i, 32'(lt_cnt), 32'(vecs[i].lt_cnt));
      chk("gt_cnt", i, 32'(gt_cnt), 32'(vecs[i].gt_cnt));
      chk("err", i, 32'(err), 32'(vecs[i].err));
    end

    // gt samples separated by 5-cycle in_valid=0 gaps
    step(0, 0, 0, 0, 0, 0);
    for (int s = 1; s <= 3; s++) begin
      step(1, 1, 0, 0, 1, 0);
      chk("gap_alarm", s, 32'(alarm), (s == 3) ? 32'd1 : 32'd0);
      chk("gap_rise", s, 32'(alarm_rise), (s == 3) ? 32'd1 : 32'd0);
      for (int g = 0; g < 5 && s < 3; g++) begin
        step(1, 0, 0, 0, 1, 0);
        chk("gap_gt_cnt", s, 32'(gt_cnt), 32'(s));
        chk("gap_run", s, 32'(run), 32'(s));
      end
    end
    chk("gap_gt_final", 3, 32'(gt_cnt), 32'd3);

    // eq_cnt saturation
    step(0, 0, 0, 0, 0, 0);
    for (int k = 1; k <= 300; k++) begin
      step(1, 1, 1, 0, 0, 0);
      if (k == 254 || k == 255 || k == 300)
        chk("eq_sat", k, 32'(eq_cnt), (k == 254) ? 32'd254 : 32'd255);
    end
    chk("eq_sat_run", 300, 32'(run), 32'd0);

    // reset while in ALARM clears everything
    for (int k = 0; k < 3; k++) step(1, 1, 0, 0, 1, 0);
    chk("pre_rst_alarm", 0, 32'(alarm), 32'd1);
    step(0, 1, 0, 0, 1, 0);
    chk("rst_alarm", 0, 32'(alarm), 32'd0);
    chk("rst_rise", 0, 32'(alarm_rise), 32'd0);
    chk("rst_run", 0, 32'(run), 32'd0);
    chk("rst_eq", 0, 32'(eq_cnt), 32'd0);
    chk("rst_gt", 0, 32'(gt_cnt), 32'd0);
    chk("rst_err", 0, 32'(err), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
